// File: rtl/burst_transfer_engine_pkg.sv
// Shared encodings for the burst transfer engine: FSM states and transfer direction.
// The arbiter uses the same values, so they must not be renumbered.
package burst_transfer_engine_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam logic RW_CORE_WRITE = 1'b1;
   localparam logic RW_CORE_READ  = 1'b0;

   // Exactly one bit set; grant vectors are zero-extended to 32 bits by the caller.
   function automatic logic is_one_hot(input logic [31:0] vec);
      return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/burst_transfer_engine_beat_counter.sv
// Beat counter with synchronous clear, increment and a flag raised when the
// next increment reaches the terminal count.
module burst_beat_counter
   import burst_transfer_engine_pkg::*;
#(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   input  logic [WIDTH-1:0] term,
   output logic [WIDTH-1:0] cnt,
   output logic             at_last
);

   logic [WIDTH-1:0] cnt_r;

   // Count register: clear wins over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (inc) begin
         cnt_r <= cnt_r + WIDTH'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt     = cnt_r;
   assign at_last = (cnt_r == (term - WIDTH'(1)));

endmodule

// File: rtl/burst_transfer_engine.sv
// Latches one granted transaction and runs its burst on the main-memory bus,
// steering beats between memory and the granted PE core, then pulses done.
module burst_transfer_engine
   import burst_transfer_engine_pkg::*;
#(
   parameter int MAIN_MEM_ADDR_WIDTH = 32,
   parameter int NUM_CORES           = 4,
   parameter int BURST_WIDTH         = 6,
   parameter int DATA_WIDTH          = 32,
   parameter int ADDR_STRIDE         = 4
) (
   input  logic                            w_clock,
   input  logic                            w_reset_n,
   input  logic [NUM_CORES-1:0]            w_grant,
   input  logic [MAIN_MEM_ADDR_WIDTH-1:0]  w_addr,
   input  logic                            w_rw,
   input  logic [BURST_WIDTH-1:0]          w_burst,
   output logic                            w_busy,
   output logic                            w_done,
   output logic                            w_err,
   output logic                            w_mem_req,
   output logic                            w_mem_we,
   output logic [MAIN_MEM_ADDR_WIDTH-1:0]  w_mem_addr,
   output logic [DATA_WIDTH-1:0]           w_mem_wdata,
   input  logic                            w_mem_ready,
   input  logic [DATA_WIDTH-1:0]           w_mem_rdata,
   input  logic                            w_mem_rvalid,
   input  logic [NUM_CORES*DATA_WIDTH-1:0] w_core_wdata,
   input  logic [NUM_CORES-1:0]            w_core_wvalid,
   output logic [NUM_CORES-1:0]            w_core_wready,
   output logic [DATA_WIDTH-1:0]           w_core_rdata,
   output logic [NUM_CORES-1:0]            w_core_rvalid
);

   localparam int SEL_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   state_e                         state_r;
   logic [NUM_CORES-1:0]           grant_r;
   logic [SEL_W-1:0]               sel_r;
   logic [MAIN_MEM_ADDR_WIDTH-1:0] addr_r;
   logic [BURST_WIDTH-1:0]         burst_r;
   logic                           busy_r;
   logic                           done_r;
   logic                           err_r;
   logic [DATA_WIDTH-1:0]          core_rdata_r;
   logic [NUM_CORES-1:0]           core_rvalid_r;

   logic [SEL_W-1:0]       sel_s;
   logic                   one_hot_s;
   logic                   launch_s;
   logic                   in_wr_s;
   logic                   in_rd_s;
   logic                   mem_req_s;
   logic                   beat_s;
   logic                   rd_accept_s;
   logic                   err_set_s;
   logic [BURST_WIDTH-1:0] req_cnt_s;
   logic [BURST_WIDTH-1:0] resp_cnt_s;
   logic                   req_last_s;
   logic                   resp_last_s;

   // One-hot grant to core index.
   always_comb begin
      sel_s = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (w_grant[i]) begin
            sel_s = SEL_W'(i);
         end else begin
            sel_s = sel_s;
         end
      end
   end

   assign one_hot_s = is_one_hot(32'(w_grant));
   assign launch_s  = (state_r == ST_IDLE) && one_hot_s;
   assign in_wr_s   = (state_r == ST_WR);
   assign in_rd_s   = (state_r == ST_RD);

   // Request generation: writes follow the selected core's valid, reads issue until all are sent.
   always_comb begin
      if (in_wr_s) begin
         mem_req_s = w_core_wvalid[sel_r];
      end else if (in_rd_s) begin
         mem_req_s = (req_cnt_s != burst_r);
      end else begin
         mem_req_s = 1'b0;
      end
   end

   assign beat_s      = mem_req_s && w_mem_ready;
   // A response with nothing outstanding is treated as an error and never forwarded.
   assign rd_accept_s = in_rd_s && w_mem_rvalid && (req_cnt_s != resp_cnt_s);
   assign err_set_s   = (w_mem_rvalid && !rd_accept_s) ||
                        ((state_r == ST_IDLE) && (w_grant != '0) && !one_hot_s);

   burst_beat_counter #(.WIDTH(BURST_WIDTH)) u_req_cnt (
      .clk     (w_clock),
      .rst_n   (w_reset_n),
      .clr     (launch_s),
      .inc     (beat_s),
      .term    (burst_r),
      .cnt     (req_cnt_s),
      .at_last (req_last_s)
   );

   burst_beat_counter #(.WIDTH(BURST_WIDTH)) u_resp_cnt (
      .clk     (w_clock),
      .rst_n   (w_reset_n),
      .clr     (launch_s),
      .inc     (rd_accept_s),
      .term    (burst_r),
      .cnt     (resp_cnt_s),
      .at_last (resp_last_s)
   );

   // Transaction FSM with its registered status and read-return outputs.
   always_ff @(posedge w_clock or negedge w_reset_n) begin
      if (!w_reset_n) begin
         state_r       <= ST_IDLE;
         grant_r       <= '0;
         sel_r         <= '0;
         addr_r        <= '0;
         burst_r       <= '0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         err_r         <= 1'b0;
         core_rdata_r  <= '0;
         core_rvalid_r <= '0;
      end else begin
         err_r         <= err_r || err_set_s;
         core_rvalid_r <= rd_accept_s ? grant_r : '0;
         core_rdata_r  <= rd_accept_s ? w_mem_rdata : core_rdata_r;
         if (beat_s) begin
            addr_r <= addr_r + MAIN_MEM_ADDR_WIDTH'(ADDR_STRIDE);
         end else if (launch_s) begin
            addr_r <= w_addr;
         end else begin
            addr_r <= addr_r;
         end
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (launch_s) begin
                  grant_r <= w_grant;
                  sel_r   <= sel_s;
                  burst_r <= w_burst;
                  busy_r  <= 1'b1;
                  if (w_burst == '0) begin
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                  end else if (w_rw == RW_CORE_WRITE) begin
                     state_r <= ST_WR;
                  end else begin
                     state_r <= ST_RD;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_WR: begin
               if (beat_s && req_last_s) begin
                  state_r <= ST_DONE;
                  done_r  <= 1'b1;
               end else begin
                  state_r <= ST_WR;
               end
            end
            ST_RD: begin
               if (rd_accept_s && resp_last_s) begin
                  state_r <= ST_DONE;
                  done_r  <= 1'b1;
               end else begin
                  state_r <= ST_RD;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign w_busy        = busy_r;
   assign w_done        = done_r;
   assign w_err         = err_r;
   assign w_mem_req     = mem_req_s;
   assign w_mem_we      = in_wr_s ? RW_CORE_WRITE : RW_CORE_READ;
   assign w_mem_addr    = addr_r;
   assign w_mem_wdata   = in_wr_s ? w_core_wdata[sel_r*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign w_core_wready = (in_wr_s && beat_s) ? grant_r : '0;
   assign w_core_rdata  = core_rdata_r;
   assign w_core_rvalid = core_rvalid_r;

endmodule

// File: tb/tb_burst_transfer_engine.sv
// Directed bench for burst_transfer_engine: a vector table of whole transactions
// plus hand sequences for reset mid-burst and a stray read response.
module tb_burst_transfer_engine;

   logic         w_clock = 1'b0;
   logic         w_reset_n = 1'b0;
   logic [3:0]   w_grant = 4'b0;
   logic [31:0]  w_addr = 32'd0;
   logic         w_rw = 1'b0;
   logic [5:0]   w_burst = 6'd0;
   logic         w_busy, w_done, w_err, w_mem_req, w_mem_we;
   logic [31:0]  w_mem_addr, w_mem_wdata;
   logic         w_mem_ready = 1'b0;
   logic [31:0]  w_mem_rdata = 32'd0;
   logic         w_mem_rvalid = 1'b0;
   logic [127:0] w_core_wdata = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
   logic [3:0]   w_core_wvalid = 4'b0;
   logic [3:0]   w_core_wready;
   logic [31:0]  w_core_rdata;
   logic [3:0]   w_core_rvalid;

   int total = 0;
   int bad = 0;

   always #5 w_clock = ~w_clock;

   burst_transfer_engine dut (
      .w_clock(w_clock), .w_reset_n(w_reset_n), .w_grant(w_grant), .w_addr(w_addr),
      .w_rw(w_rw), .w_burst(w_burst), .w_busy(w_busy), .w_done(w_done), .w_err(w_err),
      .w_mem_req(w_mem_req), .w_mem_we(w_mem_we), .w_mem_addr(w_mem_addr),
      .w_mem_wdata(w_mem_wdata), .w_mem_ready(w_mem_ready), .w_mem_rdata(w_mem_rdata),
      .w_mem_rvalid(w_mem_rvalid), .w_core_wdata(w_core_wdata), .w_core_wvalid(w_core_wvalid),
      .w_core_wready(w_core_wready), .w_core_rdata(w_core_rdata), .w_core_rvalid(w_core_rvalid)
   );

   typedef struct {
      logic [3:0]  grant;
      logic [31:0] addr;
      logic        rw;
      logic [5:0]  burst;
      int          lat;
      logic        ok;
      logic [31:0] rdy_mask;
      logic [31:0] wv_mask;
      logic [31:0] exp_wdata;
      logic [31:0] exp_last_addr;
      int          exp_done_cyc;
      logic        exp_err;
   } vec_t;

   vec_t vecs[6];
   vec_t post_vec;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctrl"}, {w_busy, w_done, w_err, w_mem_req, w_mem_we, w_core_wready, w_core_rvalid}, 64'd0);
      check({tag, "_addr"}, w_mem_addr, 64'd0);
      check({tag, "_wdata"}, w_mem_wdata, 64'd0);
      check({tag, "_rdata"}, w_core_rdata, 64'd0);
   endtask

   task automatic apply_reset();
      @(negedge w_clock);
      w_reset_n = 1'b0;
      w_grant = 4'b0; w_addr = 32'd0; w_rw = 1'b0; w_burst = 6'd0;
      w_mem_ready = 1'b0; w_mem_rvalid = 1'b0; w_mem_rdata = 32'd0; w_core_wvalid = 4'b0;
      @(negedge w_clock);
      #1 check_all_zero("reset");
      w_reset_n = 1'b1;
   endtask

   task automatic run_vec(input vec_t v, input bit do_reset);
      int sent, dut_beats, rvs;
      int due[$];
      logic [31:0] dq[$];
      logic prev_rv;
      logic [31:0] prev_data, exp_addr, last_addr;
      logic exp_req, exp_beat;
      sent = 0; dut_beats = 0; rvs = 0; prev_rv = 1'b0; prev_data = 32'd0; last_addr = 32'd0;
      if (do_reset) apply_reset();
      @(negedge w_clock);
      w_grant = v.grant; w_addr = v.addr; w_rw = v.rw; w_burst = v.burst;
      w_mem_ready = 1'b0; w_mem_rvalid = 1'b0; w_core_wvalid = 4'b0;
      #1 check("launch_idle", {w_busy, w_mem_req}, 64'd0);
      for (int c = 1; c <= 16; c++) begin
         @(negedge w_clock);
         w_grant = 4'b0;
         w_mem_ready = v.rdy_mask[c-1];
         w_core_wvalid = v.wv_mask[c-1] ? v.grant : 4'b0;
         if (due.size() > 0 && due[0] == c) begin
            w_mem_rvalid = 1'b1;
            w_mem_rdata = dq[0];
            void'(due.pop_front());
            void'(dq.pop_front());
         end else begin
            w_mem_rvalid = 1'b0;
            w_mem_rdata = 32'hDEAD_BEEF;
         end
         #1;
         check("core_rvalid", w_core_rvalid, prev_rv ? v.grant : 4'b0);
         if (prev_rv) check("core_rdata", w_core_rdata, prev_data);
         if (w_core_rvalid != 4'b0) rvs++;
         prev_rv = w_mem_rvalid;
         prev_data = w_mem_rdata;
         if (v.rw) exp_req = v.ok && (sent < int'(v.burst)) && v.wv_mask[c-1];
         else      exp_req = v.ok && (sent < int'(v.burst));
         exp_beat = exp_req && w_mem_ready;
         exp_addr = v.addr + 32'(sent * 4);
         check("mem_req", w_mem_req, exp_req);
         if (exp_req) begin
            check("mem_we", w_mem_we, v.rw);
            check("mem_addr", w_mem_addr, exp_addr);
            if (v.rw) check("mem_wdata", w_mem_wdata, v.exp_wdata);
         end
         check("core_wready", w_core_wready, (v.rw && exp_beat) ? v.grant : 4'b0);
         if (w_mem_req && w_mem_ready) begin
            dut_beats++;
            last_addr = w_mem_addr;
         end
         if (exp_beat) begin
            sent++;
            if (!v.rw) begin
               due.push_back(c + v.lat);
               dq.push_back(exp_addr ^ 32'hA500_0000);
            end
         end
         check("done", w_done, c == v.exp_done_cyc);
         check("busy", w_busy, v.ok && (c <= v.exp_done_cyc));
      end
      check("beat_count", dut_beats, v.ok ? v.burst : 6'd0);
      check("rvalid_count", rvs, (v.ok && !v.rw) ? v.burst : 6'd0);
      if (v.ok && v.burst != 6'd0) check("last_addr", last_addr, v.exp_last_addr);
      check("err", w_err, v.exp_err);
   endtask

   initial begin
      //           grant    addr          rw    burst lat ok    rdy_mask       wv_mask        wdata          last_addr     done err
      vecs[0] = '{4'b0010, 32'h0000_1000, 1'b1, 6'd4, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2222_2222, 32'h0000_100C, 5, 1'b0};
      vecs[1] = '{4'b1000, 32'h0000_2000, 1'b0, 6'd3, 2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_2008, 6, 1'b0};
      vecs[2] = '{4'b0010, 32'h0000_3000, 1'b1, 6'd2, 0, 1'b1, 32'hFFFF_FFF6, 32'hFFFF_FFFD, 32'h2222_2222, 32'h0000_3004, 6, 1'b0};
      vecs[3] = '{4'b0001, 32'h0000_7000, 1'b1, 6'd0, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1111_1111, 32'h0000_0000, 1, 1'b0};
      vecs[4] = '{4'b0110, 32'h0000_8000, 1'b1, 6'd3, 0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 0, 1'b1};
      vecs[5] = '{4'b0100, 32'hFFFF_FFFC, 1'b1, 6'd2, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h3333_3333, 32'h0000_0000, 3, 1'b0};
      post_vec = '{4'b0100, 32'h0000_6000, 1'b0, 6'd2, 3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_6004, 6, 1'b0};

      for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b1);

      // Overlapping read: responses one cycle after each request.
      run_vec('{4'b0001, 32'h0000_0040, 1'b0, 6'd5, 1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'h0000_0000, 32'h0000_0050, 7, 1'b0}, 1'b1);

      // Reset asserted during the second beat of an 8-beat write.
      apply_reset();
      @(negedge w_clock);
      w_grant = 4'b0001; w_addr = 32'h0000_5000; w_rw = 1'b1; w_burst = 6'd8;
      w_mem_ready = 1'b1; w_core_wvalid = 4'b0001;
      @(negedge w_clock);
      w_grant = 4'b0;
      #1 check("mb_beat1_addr", w_mem_addr, 32'h0000_5000);
      @(negedge w_clock);
      #1 check("mb_beat2_addr", w_mem_addr, 32'h0000_5004);
      check("mb_beat2_req", w_mem_req, 1'b1);
      w_reset_n = 1'b0;
      #1 check_all_zero("midburst_reset");
      @(negedge w_clock);
      w_reset_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge w_clock);
         #1 check("mb_after", {w_busy, w_done, w_mem_req}, 64'd0);
      end
      run_vec(post_vec, 1'b0);

      // Stray read response while idle.
      apply_reset();
      @(negedge w_clock);
      w_mem_rvalid = 1'b1; w_mem_rdata = 32'h1234_5678;
      #1 check("stray_err_before", w_err, 1'b0);
      @(negedge w_clock);
      w_mem_rvalid = 1'b0;
      #1 check("stray_err", w_err, 1'b1);
      check("stray_core_rvalid", w_core_rvalid, 4'b0);
      check("stray_busy", w_busy, 1'b0);
      @(negedge w_clock);
      #1 check("stray_err_sticky", w_err, 1'b1);
      check("stray_core_rvalid2", w_core_rvalid, 4'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
